// File: rtl/tick_pkg.sv
// Shared definitions for tick generators and tick monitors: FSM encodings,
// default meter geometry and the standard tick periods used across the design.
package tick_pkg;

  typedef enum logic {
    S_WAIT_FIRST = 1'b0,
    S_MEASURE    = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_LOCK_COUNT = 4;

  // Standard tick periods, in clock cycles
  localparam int TICK_PERIOD_FAST = 5001;
  localparam int TICK_PERIOD_SLOW = 50001;

endpackage

// File: rtl/rising_edge_detect.sv
// One-cycle rising-edge detector for a same-domain level input.
// A level already high when reset releases is reported as an edge.
module rising_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic pulse,
  output logic rise
);

  logic pulse_d;

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge value of its inputs; = here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pulse_d <= 1'b0;
    else       pulse_d <= pulse;
  end

  assign rise = pulse & ~pulse_d;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the cycle distance between successive tick rising edges, reports
// each interval with a strobe, tracks lock on repeated intervals and times out.
module tick_period_meter
  import tick_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int                RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] period_next;
  logic [RUN_W-1:0] run_len, run_next;
  logic             valid_next, locked_next, timeout_next;
  logic             rise;

  rising_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .pulse (pulse),
    .rise  (rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_WAIT_FIRST;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      run_len      <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      period       <= period_next;
      period_valid <= valid_next;
      locked       <= locked_next;
      timeout      <= timeout_next;
      run_len      <= run_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_next   = state;
    cnt_next     = cnt;
    period_next  = period;
    valid_next   = 1'b0;
    locked_next  = locked;
    timeout_next = timeout;
    run_next     = run_len;

    case (state)
      S_WAIT_FIRST: begin
        if (rise) begin
          cnt_next   = CNT_ONE;
          state_next = S_MEASURE;
        end
      end

      S_MEASURE: begin
        // An edge arriving on the saturation cycle still reports a period.
        if (rise) begin
          period_next  = cnt;
          valid_next   = 1'b1;
          cnt_next     = CNT_ONE;
          timeout_next = 1'b0;
          // run_len == 0 marks the first interval after reset or timeout.
          if (run_len == '0)       run_next = RUN_ONE;
          else if (cnt == period)  run_next = (run_len >= RUN_MAX) ? RUN_MAX : run_len + RUN_ONE;
          else                     run_next = RUN_ONE;
          locked_next = (run_next == RUN_MAX);
        end else if (cnt == CNT_MAX) begin
          timeout_next = 1'b1;
          locked_next  = 1'b0;
          run_next     = '0;
          state_next   = S_WAIT_FIRST;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: state_next = S_WAIT_FIRST;
    endcase
  end

endmodule
